// File: rtl/panda_rf_write_queue.sv
// rtl/panda_rf_write_queue.sv - in-order register-file writeback queue with operand forwarding
//
// Purpose: buffers LSU/ALU writebacks in a small FIFO, drains the head to the
// register-file write port whenever the port is free, and lets decode look up
// pending (not yet written) values by register address.
//
// Ports:
//   clk_i, rst_i                         clock, synchronous active-high reset
//   lsu_valid_i/addr_i/data_i, lsu_ready_o   load-unit writeback request (priority)
//   alu_valid_i/addr_i/data_i, alu_ready_o   ALU writeback request
//   rf_stall_i                           register-file write port busy
//   rd_addr_o/rd_data_o/rd_we_o          register-file write port (FIFO head)
//   rs1_addr_i, rs2_addr_i               decode read addresses
//   rs1_fwd_valid_o/data_o, rs2_fwd_*    youngest pending value per read port
//   count_o                              occupied entries
module panda_rf_write_queue #(
    parameter int Width  = 32,
    parameter int Depth  = 32,
    parameter int QDepth = 4,
    localparam int AW    = $clog2(Depth),
    localparam int QAW   = $clog2(QDepth),
    localparam int CW    = QAW + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             lsu_valid_i,
    input  logic [AW-1:0]    lsu_addr_i,
    input  logic [Width-1:0] lsu_data_i,
    output logic             lsu_ready_o,
    input  logic             alu_valid_i,
    input  logic [AW-1:0]    alu_addr_i,
    input  logic [Width-1:0] alu_data_i,
    output logic             alu_ready_o,
    input  logic             rf_stall_i,
    output logic [AW-1:0]    rd_addr_o,
    output logic [Width-1:0] rd_data_o,
    output logic             rd_we_o,
    input  logic [AW-1:0]    rs1_addr_i,
    input  logic [AW-1:0]    rs2_addr_i,
    output logic             rs1_fwd_valid_o,
    output logic [Width-1:0] rs1_fwd_data_o,
    output logic             rs2_fwd_valid_o,
    output logic [Width-1:0] rs2_fwd_data_o,
    output logic [CW-1:0]    count_o
);

    logic [AW-1:0]    addr_q [QDepth];
    logic [Width-1:0] data_q [QDepth];
    logic [QAW-1:0]   wr_ptr;
    logic [QAW-1:0]   rd_ptr;
    logic [CW-1:0]    count;

    logic             empty;
    logic             pop;
    logic             space;
    logic             lsu_take;
    logic             alu_take;
    logic             push;
    logic [AW-1:0]    push_addr;
    logic [Width-1:0] push_data;

    assign empty = (count == '0);
    // A write presented while reset is asserted would escape the flush, so the
    // port is held off during reset.
    assign pop   = !empty && !rf_stall_i && !rst_i;

    assign rd_we_o   = pop;
    assign rd_addr_o = empty ? '0 : addr_q[rd_ptr];
    assign rd_data_o = empty ? '0 : data_q[rd_ptr];
    assign count_o   = count;

    // A full queue still accepts when the head leaves on the same edge.
    assign space       = (count < CW'(QDepth)) || pop;
    assign lsu_ready_o = space;
    assign alu_ready_o = space && !lsu_valid_i;

    assign lsu_take  = lsu_valid_i && space;
    assign alu_take  = alu_valid_i && alu_ready_o;
    assign push_addr = lsu_valid_i ? lsu_addr_i : alu_addr_i;
    assign push_data = lsu_valid_i ? lsu_data_i : alu_data_i;
    // Writes to register 0 are accepted but dropped here.
    assign push      = (lsu_take || alu_take) && (push_addr != '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // When full with push and pop together, wr_ptr == rd_ptr: the head is
    // read combinationally before this edge overwrites the slot.
    always_ff @(posedge clk_i) begin
        if (push && !rst_i) begin
            addr_q[wr_ptr] <= push_addr;
            data_q[wr_ptr] <= push_data;
        end
    end

    // Walk occupied entries oldest to youngest so the last match wins.
    always_comb begin
        logic [QAW-1:0] idx;
        idx             = '0;
        rs1_fwd_valid_o = 1'b0;
        rs1_fwd_data_o  = '0;
        rs2_fwd_valid_o = 1'b0;
        rs2_fwd_data_o  = '0;
        for (int i = 0; i < QDepth; i++) begin
            idx = rd_ptr + QAW'(i);
            if (CW'(i) < count) begin
                if ((rs1_addr_i != '0) && (addr_q[idx] == rs1_addr_i)) begin
                    rs1_fwd_valid_o = 1'b1;
                    rs1_fwd_data_o  = data_q[idx];
                end
                if ((rs2_addr_i != '0) && (addr_q[idx] == rs2_addr_i)) begin
                    rs2_fwd_valid_o = 1'b1;
                    rs2_fwd_data_o  = data_q[idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_panda_rf_write_queue.sv
// tb/tb_panda_rf_write_queue.sv - self-checking bench for panda_rf_write_queue
module tb_panda_rf_write_queue;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        lsu_valid, alu_valid, rf_stall;
    logic [4:0]  lsu_addr, alu_addr, rs1_addr, rs2_addr;
    logic [31:0] lsu_data, alu_data;
    logic        lsu_ready, alu_ready, rd_we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data, fwd1_data, fwd2_data;
    logic        fwd1_valid, fwd2_valid;
    logic [2:0]  count;

    int compared   = 0;
    int mismatched = 0;

    ent_t        sb[$];
    logic [31:0] ref_rf [32];
    logic [31:0] dut_rf [32];

    panda_rf_write_queue dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .lsu_valid_i     (lsu_valid),
        .lsu_addr_i      (lsu_addr),
        .lsu_data_i      (lsu_data),
        .lsu_ready_o     (lsu_ready),
        .alu_valid_i     (alu_valid),
        .alu_addr_i      (alu_addr),
        .alu_data_i      (alu_data),
        .alu_ready_o     (alu_ready),
        .rf_stall_i      (rf_stall),
        .rd_addr_o       (rd_addr),
        .rd_data_o       (rd_data),
        .rd_we_o         (rd_we),
        .rs1_addr_i      (rs1_addr),
        .rs2_addr_i      (rs2_addr),
        .rs1_fwd_valid_o (fwd1_valid),
        .rs1_fwd_data_o  (fwd1_data),
        .rs2_fwd_valid_o (fwd2_valid),
        .rs2_fwd_data_o  (fwd2_data),
        .count_o         (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        lsu_valid = 1'b0;
        alu_valid = 1'b0;
    endtask

    task automatic push_alu(input logic [4:0] a, input logic [31:0] d);
        alu_valid = 1'b1;
        alu_addr  = a;
        alu_data  = d;
    endtask

    // One clock: compare outputs against the scoreboard at the falling edge,
    // then advance the model with what the DUT should accept on the next edge.
    task automatic cyc();
        logic        exp_we, exp_space, v1, v2;
        logic [4:0]  ea;
        logic [31:0] ed, d1, d2;
        @(negedge clk);
        exp_we    = (sb.size() != 0) && !rf_stall && !rst;
        ea        = (sb.size() != 0) ? sb[0].a : 5'd0;
        ed        = (sb.size() != 0) ? sb[0].d : 32'd0;
        exp_space = (sb.size() < 4) || exp_we;
        v1 = 1'b0; d1 = '0; v2 = 1'b0; d2 = '0;
        foreach (sb[k]) begin
            if (rs1_addr != 0 && sb[k].a == rs1_addr) begin v1 = 1'b1; d1 = sb[k].d; end
            if (rs2_addr != 0 && sb[k].a == rs2_addr) begin v2 = 1'b1; d2 = sb[k].d; end
        end
        check("rd_we", 64'(rd_we), 64'(exp_we));
        check("rd_addr", 64'(rd_addr), 64'(ea));
        check("rd_data", 64'(rd_data), 64'(ed));
        check("count", 64'(count), 64'(sb.size()));
        check("lsu_ready", 64'(lsu_ready), 64'(exp_space));
        check("alu_ready", 64'(alu_ready), 64'(exp_space && !lsu_valid));
        check("fwd1_valid", 64'(fwd1_valid), 64'(v1));
        check("fwd1_data", 64'(fwd1_data), 64'(d1));
        check("fwd2_valid", 64'(fwd2_valid), 64'(v2));
        check("fwd2_data", 64'(fwd2_data), 64'(d2));
        if (rd_we === 1'b1) dut_rf[rd_addr] = rd_data;
        if (rst) begin
            sb.delete();
        end else begin
            if (exp_we) void'(sb.pop_front());
            if (lsu_valid && exp_space) begin
                if (lsu_addr != 0) begin
                    sb.push_back('{lsu_addr, lsu_data});
                    ref_rf[lsu_addr] = lsu_data;
                end
            end else if (alu_valid && exp_space && !lsu_valid) begin
                if (alu_addr != 0) begin
                    sb.push_back('{alu_addr, alu_data});
                    ref_rf[alu_addr] = alu_data;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst = 1'b1; rf_stall = 1'b0;
        lsu_valid = 1'b0; lsu_addr = '0; lsu_data = '0;
        alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
        rs1_addr = '0; rs2_addr = '0;
        @(posedge clk); #1;
        cyc();
        rst = 1'b0;
        rs1_addr = 5'd5;
        #1;
        check("post_reset_we", 64'(rd_we), 64'd0);
        check("post_reset_count", 64'(count), 64'd0);
        check("post_reset_lsu_ready", 64'(lsu_ready), 64'd1);
        check("post_reset_alu_ready", 64'(alu_ready), 64'd1);
        check("post_reset_fwd1", 64'(fwd1_valid), 64'd0);

        // single ALU write
        push_alu(5'd5, 32'hDEADBEEF);
        cyc();
        idle();
        #1;
        check("alu5_we", 64'(rd_we), 64'd1);
        check("alu5_addr", 64'(rd_addr), 64'd5);
        check("alu5_data", 64'(rd_data), 64'hDEADBEEF);
        cyc();
        #1;
        check("alu5_drained", 64'(count), 64'd0);
        rs1_addr = '0;

        // LSU priority over ALU
        lsu_valid = 1'b1; lsu_addr = 5'd3; lsu_data = 32'h11;
        push_alu(5'd4, 32'h22);
        #1;
        check("prio_lsu_ready", 64'(lsu_ready), 64'd1);
        check("prio_alu_ready", 64'(alu_ready), 64'd0);
        cyc();
        lsu_valid = 1'b0;
        #1;
        check("prio_first_addr", 64'(rd_addr), 64'd3);
        check("prio_alu_taken", 64'(alu_ready), 64'd1);
        cyc();
        idle();
        #1;
        check("prio_second_addr", 64'(rd_addr), 64'd4);
        cyc();
        cyc();

        // fill under stall, then drain
        rf_stall = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            push_alu(5'(i), 32'h100 + 32'(i));
            cyc();
        end
        push_alu(5'd5, 32'h105);
        #1;
        check("full_count", 64'(count), 64'd4);
        check("full_lsu_ready", 64'(lsu_ready), 64'd0);
        check("full_alu_ready", 64'(alu_ready), 64'd0);
        cyc();
        rf_stall = 1'b0;
        #1;
        check("full_pop_addr", 64'(rd_addr), 64'd1);
        check("full_push_on_pop", 64'(alu_ready), 64'd1);
        cyc();
        idle();
        for (int i = 2; i <= 5; i++) begin
            #1;
            check("drain_order", 64'(rd_addr), 64'(i));
            cyc();
        end
        #1;
        check("drain_empty", 64'(count), 64'd0);

        // forwarding picks the youngest entry
        rf_stall = 1'b1;
        push_alu(5'd7, 32'hA);
        cyc();
        push_alu(5'd7, 32'hB);
        cyc();
        idle();
        rs1_addr = 5'd7; rs2_addr = 5'd0;
        #1;
        check("fwd_youngest_valid", 64'(fwd1_valid), 64'd1);
        check("fwd_youngest_data", 64'(fwd1_data), 64'hB);
        check("fwd_r0_valid", 64'(fwd2_valid), 64'd0);
        cyc();
        rf_stall = 1'b0;
        cyc();
        cyc();
        rs1_addr = '0;

        // register 0 writes are dropped
        lsu_valid = 1'b1; lsu_addr = 5'd0; lsu_data = 32'hFFFF;
        #1;
        check("r0_ready", 64'(lsu_ready), 64'd1);
        cyc();
        idle();
        #1;
        check("r0_count", 64'(count), 64'd0);
        check("r0_no_we", 64'(rd_we), 64'd0);

        // reset with entries queued
        rf_stall = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            push_alu(5'(i + 8), 32'h200 + 32'(i));
            cyc();
        end
        idle();
        rf_stall = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_no_we", 64'(rd_we), 64'd0);
        cyc();
        rst = 1'b0;
        #1;
        check("rst_count", 64'(count), 64'd0);
        check("rst_we", 64'(rd_we), 64'd0);

        // randomized traffic against a register model
        for (int r = 0; r < 32; r++) begin
            ref_rf[r] = '0;
            dut_rf[r] = '0;
        end
        for (int c = 0; c < 400; c++) begin
            lsu_valid = ($urandom_range(0, 3) == 0);
            lsu_addr  = 5'($urandom_range(0, 7));
            lsu_data  = $urandom;
            alu_valid = ($urandom_range(0, 1) == 0);
            alu_addr  = 5'($urandom_range(0, 7));
            alu_data  = $urandom;
            rf_stall  = ($urandom_range(0, 2) == 0);
            rs1_addr  = 5'($urandom_range(0, 7));
            rs2_addr  = 5'($urandom_range(0, 7));
            cyc();
        end
        idle();
        rf_stall = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 10) begin
            cyc();
            n++;
        end
        #1;
        check("drain_timeout", 64'(n < 10), 64'd1);
        check("final_count", 64'(count), 64'd0);
        for (int r = 0; r < 32; r++) begin
            check("final_reg", 64'(dut_rf[r]), 64'(ref_rf[r]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/panda_rf_write_queue.md
PANDA_RF_WRITE_QUEUE -- requirements
Module: panda_rf_write_queue

Interface
REQ-001 Parameter Width, default 32: register data width in bits.
REQ-002 Parameter Depth, default 32: number of architectural registers; addresses are $clog2(Depth) bits.
REQ-003 Parameter QDepth, default 4: write-queue entries; power of two, at least 2.
REQ-004 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_i  input  1  reset, synchronous and active-high.
REQ-006 lsu_valid_i / lsu_addr_i / lsu_data_i  input  1 / AW / Width  load-unit writeback request.
REQ-007 lsu_ready_o  output  1  load-unit request accepted this cycle when high with lsu_valid_i.
REQ-008 alu_valid_i / alu_addr_i / alu_data_i  input  1 / AW / Width  ALU writeback request.
REQ-009 alu_ready_o  output  1  ALU request accepted this cycle when high with alu_valid_i.
REQ-010 rf_stall_i  input  1  register-file write port unavailable this cycle.
REQ-011 rd_addr_o / rd_data_o / rd_we_o  output  AW / Width / 1  register-file write port.
REQ-012 rs1_addr_i, rs2_addr_i  input  AW  read addresses being looked up by decode.
REQ-013 rs1_fwd_valid_o / rs1_fwd_data_o, rs2_fwd_valid_o / rs2_fwd_data_o  output  1 / Width  bypass result per read port.
REQ-014 count_o  output  $clog2(QDepth)+1  number of occupied entries.

Function
REQ-015 The block SHALL hold pending writebacks in an in-order FIFO of QDepth {addr, data} entries.
REQ-016 The write port SHALL be combinational from the FIFO head: rd_we_o = !empty && !rf_stall_i; rd_addr_o and rd_data_o = head entry; both are zero when empty.
REQ-017 A pop SHALL occur on every edge where rd_we_o is high.
REQ-018 At most one push per cycle; the LSU SHALL have fixed priority over the ALU.
REQ-019 space = (count_o < QDepth) || rd_we_o; lsu_ready_o = space; alu_ready_o = space && !lsu_valid_i.
REQ-020 An accepted request with address 0 SHALL be consumed without being enqueued and SHALL never reach rd_we_o.
REQ-021 Minimum latency from accept to rd_we_o high SHALL be one cycle; there is no same-cycle pass-through.
REQ-022 Simultaneous push and pop SHALL leave count_o unchanged, including when full.
REQ-023 Read and write pointers SHALL wrap modulo QDepth; count_o SHALL never exceed QDepth nor underflow.
REQ-024 rsN_fwd_valid_o SHALL be high iff rsN_addr_i != 0 and any occupied entry has a matching address, head included.
REQ-025 rsN_fwd_data_o SHALL be the data of the youngest matching entry; it is zero when rsN_fwd_valid_o is low.
REQ-026 Forwarding SHALL reflect the queue state before this edge and SHALL NOT include requests being pushed in the same cycle.
REQ-027 Entry order to the register file SHALL equal acceptance order, so the last write to an address wins.

Reset
REQ-028 When rst_i is high at an edge, the FIFO SHALL empty, pointers SHALL go to 0, and count_o SHALL go to 0.
REQ-029 Reset SHALL override a simultaneous push or pop; requests presented during that cycle are discarded.
REQ-030 After reset: rd_we_o = 0, rd_addr_o = 0, rd_data_o = 0, all fwd_valid = 0, all fwd_data = 0, lsu_ready_o = 1, and alu_ready_o = !lsu_valid_i.
REQ-031 Reset mid-operation SHALL drop all queued entries without issuing any write.

Verification
REQ-032 After reset, push ALU addr 5 data 0xDEADBEEF with stall low -> next cycle rd_we_o = 1, rd_addr_o = 5, rd_data_o = 0xDEADBEEF; the following cycle count_o = 0.
REQ-033 Assert lsu_valid_i and alu_valid_i together (addr 3 / 0x11, addr 4 / 0x22) -> lsu_ready_o = 1 and alu_ready_o = 0; addr 3 is written first, and the ALU entry is taken the next cycle.
REQ-034 Hold rf_stall_i high and push addr 1..5 -> after 4 pushes count_o = 4 and both ready outputs are 0; release the stall -> writes occur in order 1, 2, 3, 4, and the 5th push is accepted on the first pop cycle.
REQ-035 Queue holds addr 7 / 0xA then addr 7 / 0xB, rs1_addr_i = 7, rs2_addr_i = 0 -> rs1_fwd_valid_o = 1 with data 0xB, and rs2_fwd_valid_o = 0.
REQ-036 Push addr 0 / 0xFFFF -> ready is high and count_o stays 0 with no rd_we_o; then assert rst_i with 3 entries queued -> next cycle count_o = 0 and rd_we_o = 0.
REQ-037 Randomized pushes and stalls checked against a reference register model -> final register contents match, and forwarded data always equals the youngest pending write.
